// File: rtl/weight_mem_pkg.sv
// Shared definitions for the weight-memory controller: request opcodes and FSM states.
package weight_mem_pkg;

  localparam logic [1:0] OP_RD    = 2'b00;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] OP_BURST = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/weight_mem_ctrl_if.sv
// Request/response channel bundle between a host/array master and the weight memory.
interface weight_mem_ctrl_if #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int MAX_BURST = 16
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );

endinterface

// File: rtl/weight_mem_ctrl_rsp_fifo2.sv
// Two-entry response FIFO; the head entry drives the response channel directly.
module rsp_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign pop_ok  = pop && (count_q != 2'd0);
  assign push_ok = push && ((count_q != 2'd2) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) slot_q[wr_ptr_q] <= push_data;
  end

  assign head_data = slot_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/weight_mem_ctrl.sv
// Weight-memory controller: single-word host access plus in-order burst streaming
// to the systolic array through a two-entry response buffer.
module weight_mem_ctrl
  import weight_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  weight_mem_ctrl_if.slave  bus,
  output logic              busy,
  output logic              err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  beats_left_q, beats_left_d;
  logic              err_q, err_d;
  logic              init_q;

  logic              accept;
  logic              pop;
  logic              can_issue;
  logic              push;
  logic              push_last;
  logic              mem_we;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W:0]   head_data;
  logic [1:0]        count;
  logic              buf_nonempty;

  rsp_fifo2 #(.WIDTH(DATA_W + 1)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({mem_q[rd_addr], push_last}),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

  assign buf_nonempty  = (count != 2'd0);
  assign bus.rsp_valid = buf_nonempty;
  assign bus.rsp_data  = buf_nonempty ? head_data[DATA_W:1] : '0;
  assign bus.rsp_last  = buf_nonempty && head_data[0];

  // Ready depends only on registered state so the host never sees rsp_ready ripple through.
  assign bus.req_ready = init_q && (state_q == IDLE) && (count != 2'd2);
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = buf_nonempty && bus.rsp_ready;
  assign can_issue     = (count != 2'd2) || pop;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    err_d        = 1'b0;
    push         = 1'b0;
    push_last    = 1'b0;
    mem_we       = 1'b0;
    rd_addr      = bus.req_addr;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.req_op)
            OP_WR: mem_we = 1'b1;
            OP_RD: begin
              push      = 1'b1;
              push_last = 1'b1;
            end
            OP_BURST: begin
              push         = 1'b1;
              push_last    = (bus.req_len == '0);
              cur_addr_d   = bus.req_addr + ADDR_W'(1);
              beats_left_d = bus.req_len;
              if (bus.req_len != '0) state_d = BURST;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      BURST: begin
        rd_addr = cur_addr_q;
        if (can_issue) begin
          push         = 1'b1;
          push_last    = (beats_left_q == LEN_W'(1));
          cur_addr_d   = cur_addr_q + ADDR_W'(1);
          beats_left_d = beats_left_q - LEN_W'(1);
          if (beats_left_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      err_q        <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      err_q        <= err_d;
      init_q       <= 1'b1;
    end
  end

  // Array contents survive reset; only writes change them.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[bus.req_addr] <= bus.req_wdata;
  end

  assign busy = (state_q != IDLE) || buf_nonempty;
  assign err  = err_q;

endmodule

// File: doc/weight_mem_ctrl.md
Name: weight_mem_ctrl

Overview:
- Parametrised weight-memory controller. Holds systolic-array weights in an on-chip synchronous array.
- Host side writes and reads single words through a valid/ready request channel.
- Array side streams weights through burst reads on a valid/ready response channel with backpressure.
- Single- and multi-word accesses share one request port. Responses are delivered in order at up to one word per cycle.

Parameters:
- DATA_W, 32, word width in bits.
- DEPTH, 256, number of words. Must be a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), address width. Localparam, not overridable.
- MAX_BURST, 16, maximum beats per burst. Must be a power of two.
- LEN_W, $clog2(MAX_BURST), burst-length field width. Localparam.

Ports:
- clk  input  1  Clock. All logic on the rising edge.
- rst  input  1  Reset: synchronous, active-low.
- req_valid  input  1  Request present.
- req_ready  output  1  Request accepted this cycle when req_valid && req_ready.
- req_op  input  2  Operation: 00 read, 01 write, 10 burst read, 11 reserved.
- req_addr  input  ADDR_W  Word address (start address for bursts).
- req_wdata  input  DATA_W  Write data.
- req_len  input  LEN_W  Burst beats minus 1. Ignored for ops 00 and 01.
- rsp_valid  output  1  Response word present.
- rsp_ready  input  1  Consumer takes the word when rsp_valid && rsp_ready.
- rsp_data  output  DATA_W  Read data.
- rsp_last  output  1  Final beat of a read or burst. Always 1 for a single read.
- busy  output  1  High when state != IDLE or the response buffer is non-empty.
- err  output  1  One-cycle pulse, the cycle after a reserved op is accepted.

Behaviour:
- Reset (rst==0 at a clock edge):
  - FSM goes to IDLE; response buffer is flushed.
  - rsp_valid=0, rsp_last=0, rsp_data=0, err=0, busy=0.
  - Memory array is not cleared; its contents are undefined until written.
- Reset mid-burst: the remaining beats are abandoned and no further responses appear.
- Response buffer:
  - 2-entry FIFO holding {data, last}; rsp_* are driven from the head entry.
  - A read is issued at edge E only if count<2 or a pop occurs at E.
  - Read data and last are written into the buffer at the issuing edge.
- FSM has two states, IDLE and BURST.
- IDLE behaviour:
  - req_ready = (count<2). It is a function of registered state only; there is no combinational path from rsp_ready.
  - op 01 (write): accepted → mem[req_addr]<=req_wdata at that edge. No response.
  - op 00 (read): accepted at edge t → entry {mem[req_addr], last=1} pushed; rsp_valid high from cycle t+1.
  - op 10 (burst): accepted at edge t → beat 0 pushed at t; cur_addr<=req_addr+1; beats_left<=req_len; go to BURST if req_len!=0, else remain in IDLE with last=1.
  - op 11 (reserved): accepted, no memory effect, no response, err pulses.
- BURST behaviour:
  - req_ready=0.
  - Each edge where issue is permitted: push {mem[cur_addr], last=(beats_left==1)}, cur_addr++, beats_left--.
  - After the last beat is pushed, return to IDLE.
- Address arithmetic: cur_addr is ADDR_W bits and wraps modulo DEPTH, so address DEPTH-1 is followed by 0.
- Throughput: with rsp_ready held high, a burst of N beats accepted at edge t presents beat k during cycle t+1+k.
- Backpressure: with rsp_ready low, at most 2 beats are buffered, issue stalls, and no beat is lost or duplicated. Head data is held stable while rsp_valid && !rsp_ready.
- Read-after-write: a write accepted at edge t followed by a read of the same address accepted at t+1 returns the new data. Only one request can be accepted per cycle, so there is no same-edge conflict.

Decomposition:
- Shared package weight_mem_pkg holds:
  - op encodings: OP_RD=2'b00, OP_WR=2'b01, OP_BURST=2'b10.
  - state typedef: IDLE, BURST.
- Sub-module rsp_fifo2: 2-entry FIFO, parametrised on width DATA_W+1, with push/pop/count outputs.
- The top level contains the FSM, the memory array and the address/length counters.

Test Plan:
- Reset values: hold rst=0 for 3 cycles → rsp_valid=0, req_ready=0 during reset, busy=0, err=0. After release → req_ready=1.
- Write/read: write 0xDEADBEEF @5, then read @5 on the next cycle → rsp_data=0xDEADBEEF, rsp_last=1, latency 1 cycle.
- Full-rate burst: fill addrs 0..15 with value=addr, rsp_ready=1, burst addr 0 len 15 → 16 consecutive beats 0..15, rsp_last only on beat 15, busy low afterward.
- Wrap and backpressure: DEPTH=256, burst addr 254 len 3 → data from 254, 255, 0, 1. Toggle rsp_ready 1,0,0,1,… → same sequence, no loss or duplication, data stable while stalled.
- Reset mid-burst: burst len 15, assert rst after beat 4 → rsp_valid=0 the next cycle, no further beats. A subsequent single read completes normally.
- Reserved op and width: op 11 → err pulses for exactly one cycle, memory unchanged. Rerun the write/read scenario with DATA_W=16, DEPTH=64.
